// File: rtl/fv_bank_req_arbiter_pkg.sv
// Shared constants, bank request packet and bank FSM state for fv_bank_req_arbiter.
// FV_ARB_PERF_CNT_EN adds the per-bank conflict counter width.
package fv_bank_req_arbiter_pkg;

    localparam int NUM_PE   = 4;
    localparam int NUM_BANK = 4;
    localparam int BANK_W   = $clog2(NUM_BANK);
    localparam int PE_W     = $clog2(NUM_PE);
    localparam int NODE_W   = 8;
    localparam int DATA_W   = 32;
`ifdef FV_ARB_PERF_CNT_EN
    localparam int CNT_W    = 16;
`endif

    typedef struct packed {
        logic              valid;
        logic [PE_W-1:0]   pe_tag;
        logic              rd_wr;
        logic [NODE_W-1:0] node_id;
        logic [DATA_W-1:0] data;
        logic              wr_sos;
        logic              wr_eos;
    } req2output_sram_bank_t;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_LOCKED = 1'b1
    } bank_state_e;

    function automatic logic [PE_W-1:0] onehot_to_idx(input logic [NUM_PE-1:0] oh);
        logic [PE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (oh[i]) idx = idx | PE_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fv_bank_req_arbiter_if.sv
// PE request / bank packet bundle for fv_bank_req_arbiter.
// conflict_cnt exists only when FV_ARB_PERF_CNT_EN is defined.
interface fv_bank_req_arbiter_if;
    import fv_bank_req_arbiter_pkg::*;

    logic [NUM_PE-1:0]                pe_req_valid;
    logic [NUM_PE-1:0]                pe_req_rd_wr;
    logic [NUM_PE-1:0][NODE_W-1:0]    pe_req_Node_id;
    logic [NUM_PE-1:0][DATA_W-1:0]    pe_req_data;
    logic [NUM_PE-1:0]                pe_req_wr_sos;
    logic [NUM_PE-1:0]                pe_req_wr_eos;
    logic [NUM_PE-1:0]                pe_req_ready;
    logic [NUM_BANK-1:0]              bank_available;
    req2output_sram_bank_t [NUM_BANK-1:0] bank_req_pkt;
`ifdef FV_ARB_PERF_CNT_EN
    logic [NUM_BANK-1:0][CNT_W-1:0]   conflict_cnt;
`endif

    modport master (
        output pe_req_valid, pe_req_rd_wr, pe_req_Node_id, pe_req_data,
               pe_req_wr_sos, pe_req_wr_eos, bank_available,
        input  pe_req_ready, bank_req_pkt
`ifdef FV_ARB_PERF_CNT_EN
        , input conflict_cnt
`endif
    );

    modport slave (
        input  pe_req_valid, pe_req_rd_wr, pe_req_Node_id, pe_req_data,
               pe_req_wr_sos, pe_req_wr_eos, bank_available,
        output pe_req_ready, bank_req_pkt
`ifdef FV_ARB_PERF_CNT_EN
        , output conflict_cnt
`endif
    );

endinterface

// File: rtl/fv_bank_req_arbiter_rr_arbiter.sv
// Round-robin picker: first requester after ptr (wrapping) wins, one-hot grant.
module rr_arbiter
    import fv_bank_req_arbiter_pkg::*;
(
    input  logic [NUM_PE-1:0] req,
    input  logic [PE_W-1:0]   ptr,
    output logic [NUM_PE-1:0] grant
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PE; i++) begin
            idx = (int'(ptr) + i) % NUM_PE;
            if (!found && req[PE_W'(idx)]) begin
                grant[PE_W'(idx)] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fv_bank_req_arbiter.sv
// Per-bank round-robin arbiter with write-stream locking (IDLE / LOCKED(owner)).
// Optional FV_ARB_PERF_CNT_EN adds saturating per-bank conflict counters.
module fv_bank_req_arbiter
    import fv_bank_req_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    fv_bank_req_arbiter_if.slave  bus
);

    logic [NUM_BANK-1:0][NUM_PE-1:0] bank_req;
    logic [NUM_BANK-1:0][NUM_PE-1:0] bank_gnt;
    logic [NUM_BANK-1:0][PE_W-1:0]   gnt_idx;
    logic [NUM_BANK-1:0][PE_W-1:0]   rr_ptr;
    logic [NUM_BANK-1:0][PE_W-1:0]   owner;
    bank_state_e                     state [NUM_BANK];
    req2output_sram_bank_t [NUM_BANK-1:0] pkt_q;
    logic [NUM_PE-1:0]               ready;

    // A locked bank only admits its owner, whatever the owner's rd_wr.
    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int p = 0; p < NUM_PE; p++) begin
                bank_req[b][p] = !reset
                    && bus.pe_req_valid[p]
                    && bus.bank_available[b]
                    && (bus.pe_req_Node_id[p][BANK_W-1:0] == BANK_W'(b))
                    && (state[b] == BANK_IDLE || owner[b] == PE_W'(p));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank
        rr_arbiter u_rr (
            .req   (bank_req[gb]),
            .ptr   (rr_ptr[gb]),
            .grant (bank_gnt[gb])
        );
    end

    always_comb begin
        ready   = '0;
        gnt_idx = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            ready      = ready | bank_gnt[b];
            gnt_idx[b] = onehot_to_idx(bank_gnt[b]);
        end
    end

    assign bus.pe_req_ready = ready;
    assign bus.bank_req_pkt = pkt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                pkt_q[b]  <= '0;
                rr_ptr[b] <= PE_W'(NUM_PE - 1);
                owner[b]  <= '0;
                state[b]  <= BANK_IDLE;
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (|bank_gnt[b]) begin
                    pkt_q[b].valid   <= 1'b1;
                    pkt_q[b].pe_tag  <= gnt_idx[b];
                    pkt_q[b].rd_wr   <= bus.pe_req_rd_wr[gnt_idx[b]];
                    pkt_q[b].node_id <= bus.pe_req_Node_id[gnt_idx[b]];
                    pkt_q[b].data    <= bus.pe_req_data[gnt_idx[b]];
                    pkt_q[b].wr_sos  <= bus.pe_req_wr_sos[gnt_idx[b]];
                    pkt_q[b].wr_eos  <= bus.pe_req_wr_eos[gnt_idx[b]];
                    rr_ptr[b]        <= gnt_idx[b];
                    case (state[b])
                        BANK_IDLE: begin
                            if (bus.pe_req_rd_wr[gnt_idx[b]] && bus.pe_req_wr_sos[gnt_idx[b]]
                                && !bus.pe_req_wr_eos[gnt_idx[b]]) begin
                                state[b] <= BANK_LOCKED;
                                owner[b] <= gnt_idx[b];
                            end
                        end
                        BANK_LOCKED: begin
                            if (bus.pe_req_rd_wr[gnt_idx[b]] && bus.pe_req_wr_eos[gnt_idx[b]])
                                state[b] <= BANK_IDLE;
                        end
                        default: state[b] <= BANK_IDLE;
                    endcase
                end else begin
                    pkt_q[b] <= '0;
                end
            end
        end
    end

`ifdef FV_ARB_PERF_CNT_EN
    logic [NUM_BANK-1:0][NUM_PE-1:0] bank_tgt;
    logic [NUM_BANK-1:0][CNT_W-1:0]  conflict_q;

    // Counts cycles where a valid request to the bank was left waiting, for any reason.
    always_comb begin
        bank_tgt = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int p = 0; p < NUM_PE; p++) begin
                bank_tgt[b][p] = bus.pe_req_valid[p]
                    && (bus.pe_req_Node_id[p][BANK_W-1:0] == BANK_W'(b));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (|(bank_tgt[b] & ~bank_gnt[b]) && conflict_q[b] != {CNT_W{1'b1}})
                    conflict_q[b] <= conflict_q[b] + 1'b1;
            end
        end
    end

    assign bus.conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// Bench for fv_bank_req_arbiter: directed per-PE beat schedules, a cycle model, and literal checks.
// Counter checks are compiled in when FV_ARB_PERF_CNT_EN is defined.
module tb_fv_bank_req_arbiter;
    import fv_bank_req_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fv_bank_req_arbiter_if bus();

    fv_bank_req_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit  m_locked [NUM_BANK];
    int  m_owner  [NUM_BANK];
    int  m_last   [NUM_BANK];
    req2output_sram_bank_t exp_pkt [NUM_BANK];
`ifdef FV_ARB_PERF_CNT_EN
    int  m_cnt    [NUM_BANK];
`endif

    function automatic bit targets(int p, int b);
        return bus.pe_req_valid[p] === 1'b1 && (int'(bus.pe_req_Node_id[p]) % NUM_BANK) == b;
    endfunction

    function automatic bit wants(int p, int b);
        return reset === 1'b0 && targets(p, b) && bus.bank_available[b] === 1'b1
               && (!m_locked[b] || m_owner[b] == p);
    endfunction

    function automatic int pick(int b);
        for (int k = 1; k <= NUM_PE; k++) begin
            if (wants((m_last[b] + k) % NUM_PE, b)) return (m_last[b] + k) % NUM_PE;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int g [NUM_BANK];
        if (reset) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                m_locked[b] = 1'b0;
                m_owner[b]  = 0;
                m_last[b]   = NUM_PE - 1;
                exp_pkt[b]  = '0;
`ifdef FV_ARB_PERF_CNT_EN
                m_cnt[b]    = 0;
`endif
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) g[b] = pick(b);
            for (int b = 0; b < NUM_BANK; b++) begin
`ifdef FV_ARB_PERF_CNT_EN
                begin
                    bit waiting;
                    waiting = 1'b0;
                    for (int p = 0; p < NUM_PE; p++)
                        if (targets(p, b) && p != g[b]) waiting = 1'b1;
                    if (waiting && m_cnt[b] < 65535) m_cnt[b]++;
                end
`endif
                if (g[b] < 0) begin
                    exp_pkt[b] = '0;
                end else begin
                    exp_pkt[b].valid   = 1'b1;
                    exp_pkt[b].pe_tag  = PE_W'(g[b]);
                    exp_pkt[b].rd_wr   = bus.pe_req_rd_wr[g[b]];
                    exp_pkt[b].node_id = bus.pe_req_Node_id[g[b]];
                    exp_pkt[b].data    = bus.pe_req_data[g[b]];
                    exp_pkt[b].wr_sos  = bus.pe_req_wr_sos[g[b]];
                    exp_pkt[b].wr_eos  = bus.pe_req_wr_eos[g[b]];
                    m_last[b] = g[b];
                    if (bus.pe_req_rd_wr[g[b]]) begin
                        if (!m_locked[b] && bus.pe_req_wr_sos[g[b]] && !bus.pe_req_wr_eos[g[b]]) begin
                            m_locked[b] = 1'b1;
                            m_owner[b]  = g[b];
                        end else if (m_locked[b] && bus.pe_req_wr_eos[g[b]]) begin
                            m_locked[b] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_PE-1:0] er;
        er = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (pick(b) >= 0) er[pick(b)] = 1'b1;
        end
        check("ready", 64'(bus.pe_req_ready), 64'(er));
        for (int b = 0; b < NUM_BANK; b++) begin
            check($sformatf("pkt%0d", b), 64'(bus.bank_req_pkt[b]), 64'(exp_pkt[b]));
`ifdef FV_ARB_PERF_CNT_EN
            check($sformatf("cnt%0d", b), 64'(bus.conflict_cnt[b]), 64'(m_cnt[b]));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        bit          rd_wr;
        int          node;
        logic [31:0] data;
        bit          sos;
        bit          eos;
        int          start;
    } beat_t;

    beat_t sched [NUM_PE][8];
    int    n_beats  [NUM_PE];
    int    head     [NUM_PE];
    int    last_gnt [NUM_PE];
    int    off_bank, off_start, off_end;
    bit    seen_valid [NUM_BANK][64];
    int    seen_tag   [NUM_BANK][64];

    task automatic clear_sched();
        for (int p = 0; p < NUM_PE; p++) begin
            n_beats[p] = 0; head[p] = 0; last_gnt[p] = -1;
        end
        off_bank = -1; off_start = 0; off_end = -1;
        for (int b = 0; b < NUM_BANK; b++)
            for (int c = 0; c < 64; c++) begin
                seen_valid[b][c] = 1'b0; seen_tag[b][c] = -1;
            end
    endtask

    task automatic add(int p, bit wr, int node, int data, bit sos, bit eos, int start);
        sched[p][n_beats[p]] = '{wr, node, 32'(data), sos, eos, start};
        n_beats[p]++;
    endtask

    task automatic idle_inputs();
        bus.pe_req_valid   = '0;
        bus.pe_req_rd_wr   = '0;
        bus.pe_req_Node_id = '0;
        bus.pe_req_data    = '0;
        bus.pe_req_wr_sos  = '0;
        bus.pe_req_wr_eos  = '0;
        bus.bank_available = '1;
    endtask

    task automatic drive(int cyc);
        idle_inputs();
        for (int p = 0; p < NUM_PE; p++) begin
            if (head[p] < n_beats[p] && sched[p][head[p]].start <= cyc) begin
                bus.pe_req_valid[p]   = 1'b1;
                bus.pe_req_rd_wr[p]   = sched[p][head[p]].rd_wr;
                bus.pe_req_Node_id[p] = NODE_W'(sched[p][head[p]].node);
                bus.pe_req_data[p]    = sched[p][head[p]].data;
                bus.pe_req_wr_sos[p]  = sched[p][head[p]].sos;
                bus.pe_req_wr_eos[p]  = sched[p][head[p]].eos;
            end
        end
        for (int b = 0; b < NUM_BANK; b++)
            if (b == off_bank && cyc >= off_start && cyc <= off_end) bus.bank_available[b] = 1'b0;
    endtask

    // Entered and left at posedge+1; holds each beat until the DUT raises ready for it.
    task automatic run(string name, int max_cyc);
        int cyc = 0;
        int tail = 0;
        logic [NUM_PE-1:0] r;
        while (tail < 3) begin
            bit done = 1'b1;
            for (int p = 0; p < NUM_PE; p++) if (head[p] < n_beats[p]) done = 1'b0;
            if (done) tail++;
            if (cyc >= max_cyc) begin
                vectors++; miscompares++;
                $display("FAIL %s_timeout: still pending after %0d cycles, expected completion", name, cyc);
                break;
            end
            drive(cyc);
            #1;
            r = bus.pe_req_ready;
            if (cyc < 64)
                for (int b = 0; b < NUM_BANK; b++) begin
                    seen_valid[b][cyc] = bus.bank_req_pkt[b].valid;
                    seen_tag[b][cyc]   = int'(bus.bank_req_pkt[b].pe_tag);
                end
            @(posedge clk); #1;
            for (int p = 0; p < NUM_PE; p++)
                if (r[p] === 1'b1 && head[p] < n_beats[p]) begin
                    last_gnt[p] = cyc; head[p]++;
                end
            cyc++;
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", 64'(bus.pe_req_ready), 64'd0);
        for (int b = 0; b < NUM_BANK; b++)
            check($sformatf("rst_pkt%0d", b), 64'(bus.bank_req_pkt[b]), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        clear_sched();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        clear_sched();

        // Four reads to bank 0 in the same cycle: granted PE0..PE3 in turn.
        do_reset();
        add(0, 0, 4, 'h10, 0, 0, 0);
        add(1, 0, 8, 'h11, 0, 0, 0);
        add(2, 0, 12, 'h12, 0, 0, 0);
        add(3, 0, 0, 'h13, 0, 0, 0);
        run("rr4", 20);
        for (int p = 0; p < NUM_PE; p++) begin
            check($sformatf("rr4_gnt_pe%0d", p), 64'(last_gnt[p]), 64'(p));
            check($sformatf("rr4_tag_c%0d", p + 1), 64'(seen_tag[0][p + 1]), 64'(p));
            check($sformatf("rr4_vld_c%0d", p + 1), 64'(seen_valid[0][p + 1]), 64'd1);
        end
        check("rr4_vld_c5", 64'(seen_valid[0][5]), 64'd0);

        // PE1 4-beat write stream to bank 1 blocks PE2's read until after eos.
        do_reset();
        add(1, 1, 5, 'hA0, 1, 0, 0);
        add(1, 1, 5, 'hA1, 0, 0, 0);
        add(1, 1, 5, 'hA2, 0, 0, 0);
        add(1, 1, 5, 'hA3, 0, 1, 0);
        add(2, 0, 9, 'hB0, 0, 0, 2);
        run("lock", 20);
        check("lock_eos_gnt", 64'(last_gnt[1]), 64'd3);
        check("lock_pe2_gnt", 64'(last_gnt[2]), 64'd4);
        check("lock_pe2_tag", 64'(seen_tag[1][5]), 64'd2);

        // One PE per bank: all granted in the same cycle.
        do_reset();
        for (int p = 0; p < NUM_PE; p++) add(p, 0, p, 'hC0 + p, 0, 0, 0);
        run("par", 10);
        for (int b = 0; b < NUM_BANK; b++) begin
            check($sformatf("par_gnt_pe%0d", b), 64'(last_gnt[b]), 64'd0);
            check($sformatf("par_tag_b%0d", b), 64'(seen_tag[b][1]), 64'(b));
        end

        // Bank 2 unavailable in cycles 1..3 during PE3's stream; PE0 must wait for eos.
        do_reset();
        add(3, 1, 6, 'hD0, 1, 0, 0);
        add(3, 1, 6, 'hD1, 0, 0, 0);
        add(3, 1, 6, 'hD2, 0, 0, 0);
        add(3, 1, 6, 'hD3, 0, 0, 0);
        add(3, 1, 6, 'hD4, 0, 1, 0);
        add(0, 0, 2, 'hD5, 0, 0, 1);
        off_bank = 2; off_start = 1; off_end = 3;
        run("stall", 30);
        check("stall_eos_gnt", 64'(last_gnt[3]), 64'd7);
        check("stall_pe0_gnt", 64'(last_gnt[0]), 64'd8);
        for (int c = 2; c <= 4; c++)
            check($sformatf("stall_vld_c%0d", c), 64'(seen_valid[2][c]), 64'd0);
        check("stall_resume_tag", 64'(seen_tag[2][5]), 64'd3);
        check("stall_pe0_tag", 64'(seen_tag[2][9]), 64'd0);

        // Owner reads its locked bank and uses another bank; others wait.
        do_reset();
        add(0, 1, 0, 'hE0, 1, 0, 0);
        add(0, 0, 4, 'hE1, 0, 0, 0);
        add(0, 1, 0, 'hE2, 0, 0, 0);
        add(0, 0, 1, 'hE3, 0, 0, 0);
        add(0, 1, 0, 'hE4, 0, 1, 0);
        add(1, 0, 8, 'hE5, 0, 0, 0);
        add(2, 0, 1, 'hE6, 0, 0, 3);
        run("owner", 20);
        check("owner_eos_gnt", 64'(last_gnt[0]), 64'd4);
        check("owner_pe1_gnt", 64'(last_gnt[1]), 64'd5);
        check("owner_pe2_gnt", 64'(last_gnt[2]), 64'd4);

        // Reset with bank 0 locked by PE0: PE1 granted immediately afterwards.
        do_reset();
        add(0, 1, 0, 'hF0, 1, 0, 0);
        run("pre_rst", 10);
        do_reset();
        add(1, 1, 4, 'hF1, 1, 1, 0);
        run("post_rst", 10);
        check("post_rst_gnt", 64'(last_gnt[1]), 64'd0);

`ifdef FV_ARB_PERF_CNT_EN
        do_reset();
        add(0, 0, 3, 'h30, 0, 0, 0);
        add(1, 0, 7, 'h31, 0, 0, 0);
        add(2, 0, 11, 'h32, 0, 0, 0);
        run("cnt", 10);
        check("cnt_b3_two", 64'(bus.conflict_cnt[3]), 64'd2);
        bus.pe_req_valid[0]   = 1'b1;
        bus.pe_req_Node_id[0] = NODE_W'(3);
        bus.bank_available[3] = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("cnt_b3_sat", 64'(bus.conflict_cnt[3]), 64'hFFFF);
        idle_inputs();
        @(posedge clk); #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fv_bank_req_arbiter.md
FV_BANK_REQ_ARBITER -- requirements
Module: fv_bank_req_arbiter

Interface
REQ-001 Parameter NUM_PE, 4, number of Edge PE requesters.
REQ-002 Parameter NUM_BANK, 4, number of Big FV banks (power of two); BANK_W = log2(NUM_BANK).
REQ-003 Parameter NODE_W, log2(Max_Node_id), Node_id width.
REQ-004 Parameter DATA_W, FV_bandwidth, data beat width.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pe_req_valid  in  NUM_PE  per-PE request valid.
REQ-008 pe_req_rd_wr  in  NUM_PE  per-PE 1=write, 0=read.
REQ-009 pe_req_Node_id  in  NUM_PE x NODE_W  target node.
REQ-010 pe_req_data  in  NUM_PE x DATA_W  write beat.
REQ-011 pe_req_wr_sos / pe_req_wr_eos  in  NUM_PE each  write stream start/end markers.
REQ-012 pe_req_ready  out  NUM_PE  request accepted this cycle (combinational).
REQ-013 bank_available  in  NUM_BANK  bank controller can accept a beat.
REQ-014 bank_req_pkt  out  NUM_BANK x Req2Output_SRAM_Bank  registered bank request (valid, PE_tag, rd_wr, Node_id, data, wr_sos, wr_eos).

Function
REQ-015 Target bank SHALL be Node_id[BANK_W-1:0]; Node_id forwarded unmodified.
REQ-016 Each bank SHALL run an independent round-robin arbiter over PEs with valid requests targeting it; search starts at rr_ptr+1 mod NUM_PE.
REQ-017 No grant SHALL issue to a bank while bank_available[b]=0.
REQ-018 pe_req_ready[p] SHALL be 1 exactly in the cycle PE p is granted; a PE targets one bank per cycle so at most one grant per PE.
REQ-019 Granted beat SHALL appear on bank_req_pkt[b] the next cycle with valid=1, PE_tag=p; latency exactly 1 cycle; valid=0 in cycles with no grant.
REQ-020 On grant, rr_ptr[b] SHALL update to p; no update without grant.
REQ-021 Per-bank FSM states IDLE, LOCKED(owner).
REQ-022 IDLE->LOCKED on a granted write with wr_sos=1, wr_eos=0; owner=p.
REQ-023 In LOCKED only owner SHALL be granted; other PEs wait with ready=0.
REQ-024 LOCKED->IDLE on granted owner beat with wr_eos=1.
REQ-025 Write with wr_sos=1 and wr_eos=1 SHALL be single beat; FSM stays IDLE.
REQ-026 Reads SHALL be single beat, never lock; a locked owner's read to the locked bank is granted and does not alter lock.
REQ-027 bank_available=0 while LOCKED SHALL stall the stream; lock retained.
REQ-028 Owner requests to other banks SHALL arbitrate normally there.

Reset
REQ-029 On reset: all bank_req_pkt fields 0, pe_req_ready 0, all FSMs IDLE, rr_ptr = NUM_PE-1 (PE0 first priority).
REQ-030 Reset asserted mid-stream SHALL drop all locks; no eos required afterwards.

Configuration
REQ-031 Macro FV_ARB_PERF_CNT_EN defined: per-bank 16-bit saturating conflict_cnt output (NUM_BANK x 16), incremented each cycle a bank has >=1 valid request not granted; cleared by reset; saturates at 0xFFFF.
REQ-032 Macro undefined: no counters, port absent; all other behaviour identical.

Structure
REQ-033 Req2Output_SRAM_Bank and NUM_BANK/NUM_PE constants SHALL come from the shared sys_defs package; bank FSM state enum SHALL be added there.
REQ-034 One sub-module rr_arbiter (NUM_PE-wide request, pointer in, one-hot grant out) SHALL be instantiated per bank.

Verification
REQ-035 PE0..3 read Node_id 4,8,12,0 (all bank 0) same cycle after reset -> grants PE0,PE1,PE2,PE3 on consecutive cycles; packets one cycle later.
REQ-036 PE1 write stream Node_id 5 (bank 1) sos..eos 4 beats, PE2 reads Node_id 9 from cycle 2 -> PE2 ready=0 until cycle after eos grant, then granted.
REQ-037 PE0..3 target banks 0..3 respectively -> all four granted same cycle, four packets next cycle with matching PE_tag.
REQ-038 bank_available[2]=0 for 3 cycles during PE3 stream to bank 2 -> no bank 2 packets in those cycles; stream resumes, lock held.
REQ-039 Reset asserted after PE0 sos to bank 0 -> post-reset PE1 write to bank 0 granted immediately.
REQ-040 FV_ARB_PERF_CNT_EN: 3 PEs contend for bank 3 for 2 cycles -> conflict_cnt[3]=2; forced 70000 conflict cycles -> 0xFFFF.
